// File: rtl/serial_subtractor.sv
// Bit-serial 8-bit subtractor: one full-subtractor cell plus a borrow flop,
// LSB first, with a start/busy/done handshake and a registered result.
module serial_subtractor (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] y,
  output logic       borrowOut,
  output logic       busy,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t     state;
  state_t     state_next;
  logic [7:0] a_sh;
  logic [7:0] b_sh;
  logic [7:0] result;
  logic [2:0] count;
  logic       borrow;
  logic       accept;
  logic       last_bit;
  logic       d_bit;
  logic       bout;

  // Handshake: start is accepted only in IDLE or DONE (accept=1); start seen
  // during SHIFT is dropped. busy and done decode mutually exclusive states.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = DONE;
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          accept     = 1'b1;
          state_next = SHIFT;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign last_bit = (count == 3'd7);
  assign d_bit    = a_sh[0] ^ b_sh[0] ^ borrow;
  assign bout     = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      a_sh      <= 8'h00;
      b_sh      <= 8'h00;
      result    <= 8'h00;
      count     <= 3'd0;
      borrow    <= 1'b0;
      y         <= 8'h00;
      borrowOut <= 1'b0;
    end else begin
      state <= state_next;
      if (accept) begin
        a_sh   <= a;
        b_sh   <= b;
        result <= 8'h00;
        count  <= 3'd0;
        borrow <= 1'b0;
      end else if (state == SHIFT) begin
        a_sh   <= {1'b0, a_sh[7:1]};
        b_sh   <= {1'b0, b_sh[7:1]};
        result <= {d_bit, result[7:1]};
        count  <= count + 3'd1;
        borrow <= bout;
        // The outputs only ever see a finished word, never the partial one.
        if (last_bit) begin
          y         <= {d_bit, result[7:1]};
          borrowOut <= bout;
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed plan cases plus random
// operands, checked against an integer-arithmetic reference model.
module tb_serial_subtractor;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] y;
  logic       borrowOut;
  logic       busy;
  logic       done;

  int checks = 0;
  int errors = 0;
  logic [8:0] exp_q[$];

  serial_subtractor dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
    .y(y), .borrowOut(borrowOut), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Reference: plain signed difference, wrapped to 8 bits; borrow when negative.
  function automatic logic [8:0] model(input logic [7:0] av, input logic [7:0] bv);
    int diff;
    diff = int'(av) - int'(bv);
    return {diff < 0, 8'((diff + 256) % 256)};
  endfunction

  // Called at a falling edge; returns one falling edge after the accepting edge.
  task automatic issue(input logic [7:0] av, input logic [7:0] bv);
    start = 1'b1;
    a = av;
    b = bv;
    exp_q.push_back(model(av, bv));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int n, output int busy_n, output bit overlap,
                           output bit timeout);
    n = 0; busy_n = 0; overlap = 1'b0; timeout = 1'b0;
    while (!done) begin
      if (busy) busy_n++;
      n++;
      if (n > 40) begin
        timeout = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (busy && done) overlap = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checks++;
    if ({y, borrowOut, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL reset_outputs: got y=%h bo=%b busy=%b done=%b, want all 0",
               y, borrowOut, busy, done);
    end
    @(negedge clk);
  endtask

  task automatic test_vectors();
    logic [7:0] va[5] = '{8'd200, 8'd55, 8'h00, 8'hAA, 8'hFF};
    logic [7:0] vb[5] = '{8'd55, 8'd200, 8'h01, 8'hAA, 8'h00};
    int n, busy_n;
    bit overlap, timeout;
    logic [8:0] exp;
    for (int i = 0; i < 25; i++) begin
      if (i < 5) issue(va[i], vb[i]);
      else issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
      wait_done(n, busy_n, overlap, timeout);
      exp = exp_q.pop_front();
      checks++;
      if (timeout || n != 8 || busy_n != 8 || overlap) begin
        errors++;
        $display("FAIL op%0d_timing: latency=%0d busy_cycles=%0d overlap=%0b timeout=%0b, want 8/8/0/0",
                 i, n, busy_n, overlap, timeout);
      end
      checks++;
      if ({borrowOut, y} !== exp) begin
        errors++;
        $display("FAIL op%0d_result: got y=%h bo=%b, want y=%h bo=%b",
                 i, y, borrowOut, exp[7:0], exp[8]);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_ignored_start();
    int n, busy_n, extra;
    bit overlap, timeout;
    logic [8:0] exp;
    issue(8'd10, 8'd3);
    for (int c = 1; c < 8; c++) begin
      a = 8'($urandom_range(0, 255));
      b = 8'($urandom_range(0, 255));
      start = (c == 4);
      if (c == 4) begin a = 8'd99; b = 8'd1; end
      @(negedge clk);
    end
    start = 1'b0;
    wait_done(n, busy_n, overlap, timeout);
    exp = exp_q.pop_front();
    checks++;
    if (timeout || {borrowOut, y} !== exp) begin
      errors++;
      $display("FAIL ignored_start_result: got y=%h bo=%b timeout=%0b, want y=%h bo=%b",
               y, borrowOut, timeout, exp[7:0], exp[8]);
    end
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0 || {borrowOut, y} !== exp) begin
      errors++;
      $display("FAIL ignored_start_quiet: extra activity=%0d y=%h bo=%b, want 0 and held y=%h",
               extra, y, borrowOut, exp[7:0]);
    end
  endtask

  task automatic test_back_to_back();
    int n, busy_n;
    bit overlap, timeout;
    logic [8:0] exp;
    start = 1'b1; a = 8'd100; b = 8'd1;
    exp_q.push_back(model(8'd100, 8'd1));
    @(negedge clk);
    wait_done(n, busy_n, overlap, timeout);
    exp = exp_q.pop_front();
    checks++;
    if (timeout || overlap || {borrowOut, y} !== exp) begin
      errors++;
      $display("FAIL b2b_first: got y=%h bo=%b timeout=%0b overlap=%0b, want y=%h bo=%b",
               y, borrowOut, timeout, overlap, exp[7:0], exp[8]);
    end
    a = 8'd1; b = 8'd2;
    exp_q.push_back(model(8'd1, 8'd2));
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_relaunch: got busy=%b done=%b, want busy=1 done=0", busy, done);
    end
    wait_done(n, busy_n, overlap, timeout);
    exp = exp_q.pop_front();
    checks++;
    if (timeout || overlap || n + 1 != 9) begin
      errors++;
      $display("FAIL b2b_spacing: done spacing=%0d overlap=%0b timeout=%0b, want 9",
               n + 1, overlap, timeout);
    end
    checks++;
    if ({borrowOut, y} !== exp) begin
      errors++;
      $display("FAIL b2b_second: got y=%h bo=%b, want y=%h bo=%b",
               y, borrowOut, exp[7:0], exp[8]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n, busy_n, extra;
    bit overlap, timeout;
    logic [8:0] exp;
    issue(8'd50, 8'd20);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    void'(exp_q.pop_front());
    checks++;
    if ({y, borrowOut, busy, done} !== 11'd0) begin
      errors++;
      $display("FAIL reset_mid_outputs: got y=%h bo=%b busy=%b done=%b, want all 0",
               y, borrowOut, busy, done);
    end
    extra = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (extra != 0) begin
      errors++;
      $display("FAIL reset_mid_discard: activity cycles=%0d, want 0", extra);
    end
    issue(8'd50, 8'd20);
    wait_done(n, busy_n, overlap, timeout);
    exp = exp_q.pop_front();
    checks++;
    if (timeout || n != 8 || {borrowOut, y} !== exp) begin
      errors++;
      $display("FAIL reset_mid_restart: got y=%h bo=%b latency=%0d timeout=%0b, want y=%h bo=%b latency=8",
               y, borrowOut, n, timeout, exp[7:0], exp[8]);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; a = 8'h00; b = 8'h00;
    @(negedge clk);
    test_reset();
    test_vectors();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
